// File: rtl/qar_core_mc.sv
// Multi-cycle RV32I-subset core: FETCH -> EXEC (-> MEM) with an internal 32x32 register file.
// Traps (illegal, misaligned, EBREAK) park the core in HALT until reset.
module qar_core_mc #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int unsigned IMEM_AW          = 30,
  parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        retire_o,
  output logic        halted_o,
  output logic [1:0]  trap_cause_o
);

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

  localparam logic [6:0]  OpLui    = 7'b0110111;
  localparam logic [6:0]  OpJal    = 7'b1101111;
  localparam logic [6:0]  OpBranch = 7'b1100011;
  localparam logic [6:0]  OpLoad   = 7'b0000011;
  localparam logic [6:0]  OpStore  = 7'b0100011;
  localparam logic [6:0]  OpImm    = 7'b0010011;
  localparam logic [6:0]  OpReg    = 7'b0110011;
  localparam logic [31:0] Ebreak   = 32'h0010_0073;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d;
  logic [31:0] maddr_q, maddr_d, wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  trap_q, trap_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [31:0] rf_wdata;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] alu_b, alu_res, wr_val, pc_next, mem_addr;
  logic        alu_ok, is_sub, wr_en, redirect, is_mem, is_store, illegal, ebreak, misalign;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign f7     = ir_q[31:25];
  assign rs1_v  = rf_q[ir_q[19:15]];
  assign rs2_v  = rf_q[ir_q[24:20]];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'h000};
  assign alu_b  = (opcode == OpReg) ? rs2_v : imm_i;
  assign is_sub = (opcode == OpReg) && (f7 == 7'b0100000);

  // Shared ALU for OP and OP-IMM; alu_ok flags encodings outside the supported subset.
  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    unique case (f3)
      3'b000:  alu_res = is_sub ? rs1_v - alu_b : rs1_v + alu_b;
      3'b001:  alu_res = rs1_v << alu_b[4:0];
      3'b100:  alu_res = rs1_v ^ alu_b;
      3'b101:  alu_res = rs1_v >> alu_b[4:0];
      3'b110:  alu_res = rs1_v | alu_b;
      3'b111:  alu_res = rs1_v & alu_b;
      default: alu_ok  = 1'b0;
    endcase
    if (opcode == OpImm && (f3 == 3'b001 || f3 == 3'b101) && f7 != 7'b0) alu_ok = 1'b0;
    if (opcode == OpReg && f7 != 7'b0 && !(is_sub && f3 == 3'b000)) alu_ok = 1'b0;
  end

  always_comb begin
    illegal  = 1'b0;
    ebreak   = 1'b0;
    wr_en    = 1'b0;
    wr_val   = alu_res;
    pc_next  = pc_q + 32'd4;
    redirect = 1'b0;
    is_mem   = 1'b0;
    is_store = 1'b0;
    mem_addr = rs1_v + imm_i;
    misalign = 1'b0;
    case (opcode)
      OpLui: begin
        wr_en  = 1'b1;
        wr_val = imm_u;
      end
      OpJal: begin
        wr_en    = 1'b1;
        wr_val   = pc_q + 32'd4;
        pc_next  = pc_q + imm_j;
        redirect = 1'b1;
      end
      OpBranch: begin
        if (f3 == 3'b000 || f3 == 3'b001) begin
          if ((rs1_v != rs2_v) == f3[0]) begin
            pc_next  = pc_q + imm_b;
            redirect = 1'b1;
          end
        end else begin
          illegal = 1'b1;
        end
      end
      OpLoad:  if (f3 == 3'b010) is_mem = 1'b1; else illegal = 1'b1;
      OpStore: begin
        mem_addr = rs1_v + imm_s;
        if (f3 == 3'b010) begin
          is_mem   = 1'b1;
          is_store = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OpImm, OpReg: begin
        wr_en   = alu_ok;
        illegal = !alu_ok;
      end
      default: begin
        if (ir_q == Ebreak) ebreak = 1'b1;
        else illegal = 1'b1;
      end
    endcase
    if (redirect && pc_next[1:0] != 2'b00) begin
      if (TRAP_ON_MISALIGN) misalign = 1'b1;
      else pc_next[1:0] = 2'b00;
    end
    if (is_mem && mem_addr[1:0] != 2'b00) begin
      if (TRAP_ON_MISALIGN) misalign = 1'b1;
      else mem_addr[1:0] = 2'b00;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    maddr_d  = maddr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    trap_d   = trap_q;
    rf_we    = 1'b0;
    rf_wdata = wr_val;
    retire_o = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (imem_ready_i) begin
          ir_d    = imem_rdata_i;
          state_d = StExec;
        end
      end
      StExec: begin
        if (ebreak) begin
          trap_d  = 2'd3;
          state_d = StHalt;
        end else if (illegal) begin
          trap_d  = 2'd1;
          state_d = StHalt;
        end else if (misalign) begin
          trap_d  = 2'd2;
          state_d = StHalt;
        end else if (is_mem) begin
          maddr_d = mem_addr;
          we_d    = is_store;
          wdata_d = rs2_v;
          state_d = StMem;
        end else begin
          rf_we    = wr_en;
          pc_d     = pc_next;
          retire_o = 1'b1;
          state_d  = StFetch;
        end
      end
      StMem: begin
        if (dmem_ready_i) begin
          rf_we    = !we_q;
          rf_wdata = dmem_rdata_i;
          pc_d     = pc_q + 32'd4;
          retire_o = 1'b1;
          state_d  = StFetch;
        end
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      trap_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      trap_q  <= trap_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && rd != 5'd0) begin
      rf_q[rd] <= rf_wdata;
    end
  end

  // Requests are gated by rst_n so an in-flight access drops the instant reset asserts.
  assign imem_req_o   = rst_n && (state_q == StFetch);
  assign imem_addr_o  = imem_req_o ? (32'(pc_q[IMEM_AW+1:2]) << 2) : 32'h0;
  assign dmem_req_o   = rst_n && (state_q == StMem);
  assign dmem_we_o    = dmem_req_o && we_q;
  assign dmem_addr_o  = maddr_q;
  assign dmem_wdata_o = wdata_q;
  assign halted_o     = (state_q == StHalt);
  assign trap_cause_o = trap_q;

endmodule
